icache_axi_refill: RTL and testbench
====================================

// Module: icache_axi_refill
// PURPOSE
//  AXI4 read-side responder for the instruction-cache controller's refill request.
//  Takes a line-fill request (mem_req + address), issues one AXI4 read burst, and
//  assembles the R beats into one cache line. Pulses mem_done with the line, which
//  the cache writes in its update cycle. Sits between the I-cache controller and the AXI fabric.
// PARAMETERS
//  ADDR_WIDTH     64   request/AXI address width
//  LINE_WIDTH     256  cache line width (bits); LINE_BYTES = LINE_WIDTH/8 = 32
//  AXI_DATA_WIDTH 64   AXI R data width; BEATS = LINE_WIDTH/AXI_DATA_WIDTH = 4
//  AXI_ID_WIDTH   4    AXI ID width
//  AXI_ID         0    constant ID driven on arid
// PORTS
//  i_clk          in   1               clock, rising edge
//  i_rst_n        in   1               async active-low reset
//  i_mem_req      in   1               refill request from cache controller (level)
//  i_mem_addr     in   ADDR_WIDTH      refill address (line-aligned by controller)
//  o_mem_done     out  1               1-cycle pulse: o_line_data valid
//  o_line_data    out  LINE_WIDTH      assembled line; beat k at [k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH]
//  o_bus_err      out  1               sticky: bad rresp or rlast mismatch seen
//  o_arvalid      out  1               AXI AR valid
//  i_arready      in   1               AXI AR ready
//  o_araddr       out  ADDR_WIDTH      AXI AR address
//  o_arlen        out  8               BEATS-1 (constant 3 at default)
//  o_arsize       out  3               log2(AXI_DATA_WIDTH/8) (3 at default)
//  o_arburst      out  2               2'b01 INCR (2'b10 WRAP with macro)
//  o_arid         out  AXI_ID_WIDTH    AXI_ID
//  i_rvalid       in   1               AXI R valid
//  o_rready       out  1               AXI R ready
//  i_rdata        in   AXI_DATA_WIDTH  AXI R data
//  i_rresp        in   2               AXI R response
//  i_rlast        in   1               AXI R last
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state IDLE; o_arvalid, o_rready, o_mem_done, o_bus_err = 0;
//   o_araddr, o_line_data = 0; beat counter = 0. Reset mid-burst aborts it; the AXI slave must be reset too.
//  FSM: IDLE -> AR -> RDATA -> DONE -> IDLE.
//   IDLE: i_mem_req=1 -> latch araddr = {i_mem_addr[ADDR_WIDTH-1:5],5'b0}; clear beat count; next AR.
//   AR: o_arvalid=1, araddr stable until i_arready; on handshake -> RDATA. arvalid never drops before arready.
//   RDATA: o_rready=1; each i_rvalid&o_rready writes i_rdata into beat slot cnt, cnt++.
//    End of burst: i_rlast accepted OR cnt==BEATS-1 accepted -> DONE.
//    i_rresp!=2'b00 on any beat -> o_bus_err=1 (sticky until reset); burst still completes.
//    i_rlast on beat != BEATS-1, or beat BEATS-1 without i_rlast -> o_bus_err=1; end burst at first of the two.
//   DONE: o_mem_done=1 for exactly one cycle; o_line_data held until next IDLE->AR transition; -> IDLE.
//  Latency (zero-wait slave): req @c0 -> arvalid @c1 -> beats @c2..c5 -> mem_done @c6.
//  i_mem_req dropped mid-transaction: ignored; burst completes and done still pulses.
//  i_mem_req still high in the DONE cycle: not a new request; one is only sampled in IDLE.
//  Beat counter width clog2(BEATS); wraps modulo BEATS.
// CONFIGURATION
//  ICACHE_CRITICAL_WORD_FIRST_EN defined: o_arburst=WRAP,
//   araddr = {i_mem_addr[ADDR_WIDTH-1:3],3'b0}; start slot = i_mem_addr[4:3]; slot = start+cnt mod BEATS,
//   so o_line_data stays in natural order.
//  Not defined: INCR from the line base; slot = cnt; i_mem_addr[4:0] ignored.
// TESTING
//  1 req addr 0x1000_0040, zero-wait slave, beats D0..D3 -> araddr 0x...40, arlen 3, arsize 3,
//    mem_done @c6, line={D3,D2,D1,D0}.
//  2 arready held low 5 cycles, rvalid gapped -> arvalid/araddr stable; line correct; exactly one done pulse.
//  3 rresp=2'b10 on beat 1 -> o_bus_err=1 and stays 1; done still pulses after beat 3.
//  4 rlast on beat 1 -> done after beat 1, o_bus_err=1; next clean req completes normally.
//  5 reset asserted during RDATA beat 2 -> all outputs 0 immediately; next req runs cleanly.
//  6 macro on, addr 0x...50 -> arburst WRAP, araddr 0x...50, beats land in slots 2,3,0,1.

Source files
------------

// File: rtl/icache_axi_refill.sv
// icache_axi_refill: AXI4 read-burst refill engine for the instruction cache.
// Takes a line-fill request, issues one AR burst, collects the R beats into a
// full cache line and pulses o_mem_done with the assembled line.
// Optional build macro: ICACHE_CRITICAL_WORD_FIRST_EN (WRAP burst starting at
// the requested word; beats are steered so o_line_data stays in natural order).
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. o_arvalid is raised in AR and held, with o_araddr stable,
// until i_arready; o_rready is high for the whole RDATA state and a beat is
// taken on every edge with i_rvalid high there.
module icache_axi_refill #(
  parameter int ADDR_WIDTH     = 64,
  parameter int LINE_WIDTH     = 256,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_ID         = 0
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_mem_req,
  input  logic [ADDR_WIDTH-1:0]     i_mem_addr,
  output logic                      o_mem_done,
  output logic [LINE_WIDTH-1:0]     o_line_data,
  output logic                      o_bus_err,
  output logic                      o_arvalid,
  input  logic                      i_arready,
  output logic [ADDR_WIDTH-1:0]     o_araddr,
  output logic [7:0]                o_arlen,
  output logic [2:0]                o_arsize,
  output logic [1:0]                o_arburst,
  output logic [AXI_ID_WIDTH-1:0]   o_arid,
  input  logic                      i_rvalid,
  output logic                      o_rready,
  input  logic [AXI_DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]                i_rresp,
  input  logic                      i_rlast,
  output logic [1:0]                o_dbg_state
);

  localparam int BEATS    = LINE_WIDTH / AXI_DATA_WIDTH;
  localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BYTE_OFF = $clog2(AXI_DATA_WIDTH / 8);
  localparam int LINE_OFF = $clog2(LINE_WIDTH / 8);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_AR    = 2'd1;
  localparam logic [1:0] S_RDATA = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state_q,   state_d;
  logic [ADDR_WIDTH-1:0] araddr_q,  araddr_d;
  logic [LINE_WIDTH-1:0] line_q,    line_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic [CNT_W-1:0]      start_q,   start_d;
  logic                  bus_err_q, bus_err_d;

  logic [ADDR_WIDTH-1:0] req_araddr;
  logic [CNT_W-1:0]      req_start;
  logic [CNT_W-1:0]      slot;
  logic                  last_beat;
  logic                  unused_addr_bits;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  // Burst starts at the requested word and wraps inside the line.
  assign req_araddr       = {i_mem_addr[ADDR_WIDTH-1:BYTE_OFF], {BYTE_OFF{1'b0}}};
  assign req_start        = i_mem_addr[LINE_OFF-1:BYTE_OFF];
  assign o_arburst        = 2'b10;
  assign unused_addr_bits = ^i_mem_addr[BYTE_OFF-1:0];
`else
  // Burst always starts at the line base; the offset bits carry no meaning.
  assign req_araddr       = {i_mem_addr[ADDR_WIDTH-1:LINE_OFF], {LINE_OFF{1'b0}}};
  assign req_start        = '0;
  assign o_arburst        = 2'b01;
  assign unused_addr_bits = ^i_mem_addr[LINE_OFF-1:0];
`endif

  // Constant burst shape and the state-decoded handshake outputs.
  assign o_arlen     = 8'(BEATS - 1);
  assign o_arsize    = 3'(BYTE_OFF);
  assign o_arid      = AXI_ID_WIDTH'(AXI_ID);
  assign o_arvalid   = (state_q == S_AR);
  assign o_rready    = (state_q == S_RDATA);
  assign o_mem_done  = (state_q == S_DONE);
  assign o_araddr    = araddr_q;
  assign o_line_data = line_q;
  assign o_bus_err   = bus_err_q;
  assign o_dbg_state = state_q;

  // Beat slot in the line (rotated by the start word when wrapping) and
  // whether the current beat is the last one the line expects.
  assign slot      = start_q + cnt_q;
  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

  // Next-state and datapath update for the refill sequence.
  always_comb begin
    state_d   = state_q;
    araddr_d  = araddr_q;
    line_d    = line_q;
    cnt_d     = cnt_q;
    start_d   = start_q;
    bus_err_d = bus_err_q;
    case (state_q)
      S_IDLE: begin
        if (i_mem_req) begin
          araddr_d = req_araddr;
          start_d  = req_start;
          cnt_d    = '0;
          line_d   = '0;
          state_d  = S_AR;
        end
      end
      S_AR: begin
        if (i_arready) begin
          state_d = S_RDATA;
        end
      end
      S_RDATA: begin
        if (i_rvalid) begin
          for (int k = 0; k < BEATS; k++) begin
            if (slot == CNT_W'(k)) begin
              line_d[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = i_rdata;
            end
          end
          cnt_d = cnt_q + CNT_W'(1);
          // Error response or a burst length that disagrees with the line
          // size is flagged, but the line is still handed back.
          if (i_rresp != 2'b00) begin
            bus_err_d = 1'b1;
          end
          if (i_rlast != last_beat) begin
            bus_err_d = 1'b1;
          end
          if (i_rlast || last_beat) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      araddr_q  <= '0;
      line_q    <= '0;
      cnt_q     <= '0;
      start_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      line_q    <= line_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_icache_axi_refill.sv
// Directed testbench for icache_axi_refill: reset values, zero-wait refill,
// AR back-pressure with gapped R beats, error responses, rlast mismatches,
// reset mid-burst and the critical-word-first address/slot mapping.
module tb_icache_axi_refill;

  logic         i_clk;
  logic         i_rst_n;
  logic         i_mem_req;
  logic [63:0]  i_mem_addr;
  logic         o_mem_done;
  logic [255:0] o_line_data;
  logic         o_bus_err;
  logic         o_arvalid;
  logic         i_arready;
  logic [63:0]  o_araddr;
  logic [7:0]   o_arlen;
  logic [2:0]   o_arsize;
  logic [1:0]   o_arburst;
  logic [3:0]   o_arid;
  logic         i_rvalid;
  logic         o_rready;
  logic [63:0]  i_rdata;
  logic [1:0]   i_rresp;
  logic         i_rlast;
  logic [1:0]   o_dbg_state;

  int checks = 0;
  int errors = 0;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  localparam logic [1:0]  EXP_BURST  = 2'b10;
  localparam logic [63:0] EXP6_ADDR  = 64'h0000_0000_6000_0050;
`else
  localparam logic [1:0]  EXP_BURST  = 2'b01;
  localparam logic [63:0] EXP6_ADDR  = 64'h0000_0000_6000_0040;
`endif

  icache_axi_refill dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_mem_req   (i_mem_req),
    .i_mem_addr  (i_mem_addr),
    .o_mem_done  (o_mem_done),
    .o_line_data (o_line_data),
    .o_bus_err   (o_bus_err),
    .o_arvalid   (o_arvalid),
    .i_arready   (i_arready),
    .o_araddr    (o_araddr),
    .o_arlen     (o_arlen),
    .o_arsize    (o_arsize),
    .o_arburst   (o_arburst),
    .o_arid      (o_arid),
    .i_rvalid    (i_rvalid),
    .o_rready    (o_rready),
    .i_rdata     (i_rdata),
    .i_rresp     (i_rresp),
    .i_rlast     (i_rlast),
    .o_dbg_state (o_dbg_state)
  );

  // Clock: 10 time-unit period.
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    i_rst_n   = 1'b0;
    i_mem_req = 1'b0;
    i_arready = 1'b0;
    i_rvalid  = 1'b0;
    i_rlast   = 1'b0;
    i_rresp   = 2'b00;
    i_rdata   = '0;
    tick();
    i_rst_n = 1'b1;
    tick();
  endtask

  // Raise a request, check the AR channel, hold arready low for ar_wait
  // cycles, then complete the AR handshake. Leaves the DUT in RDATA.
  task automatic start_req(input logic [63:0] a, input logic [63:0] exp_addr, input int ar_wait);
    i_mem_req  = 1'b1;
    i_mem_addr = a;
    i_arready  = 1'b0;
    tick();
    chk("ar_valid",  256'(o_arvalid), 256'(1));
    chk("ar_addr",   256'(o_araddr),  256'(exp_addr));
    chk("ar_len",    256'(o_arlen),   256'(3));
    chk("ar_size",   256'(o_arsize),  256'(3));
    chk("ar_burst",  256'(o_arburst), 256'(EXP_BURST));
    chk("ar_id",     256'(o_arid),    256'(0));
    i_mem_req  = 1'b0;
    i_mem_addr = 64'hdead_beef_dead_beef;
    for (int i = 0; i < ar_wait; i++) begin
      tick();
      chk("ar_hold_valid", 256'(o_arvalid), 256'(1));
      chk("ar_hold_addr",  256'(o_araddr),  256'(exp_addr));
    end
    i_arready = 1'b1;
    tick();
    i_arready = 1'b0;
    chk("rd_rready",  256'(o_rready),  256'(1));
    chk("rd_arvalid", 256'(o_arvalid), 256'(0));
  endtask

  // One R beat after gap idle cycles; done must stay low until it is taken.
  task automatic beat(input logic [63:0] d, input logic [1:0] resp, input logic last, input int gap);
    i_rvalid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      tick();
      chk("gap_done",   256'(o_mem_done), 256'(0));
      chk("gap_rready", 256'(o_rready),   256'(1));
    end
    i_rvalid = 1'b1;
    i_rdata  = d;
    i_rresp  = resp;
    i_rlast  = last;
    chk("beat_done", 256'(o_mem_done), 256'(0));
    tick();
    i_rvalid = 1'b0;
    i_rlast  = 1'b0;
    i_rresp  = 2'b00;
    i_rdata  = '0;
  endtask

  initial begin
    i_rst_n    = 1'b0;
    i_mem_req  = 1'b0;
    i_mem_addr = '0;
    i_arready  = 1'b0;
    i_rvalid   = 1'b0;
    i_rdata    = '0;
    i_rresp    = 2'b00;
    i_rlast    = 1'b0;
    tick();
    tick();

    // Reset values.
    chk("rst_arvalid", 256'(o_arvalid),   256'(0));
    chk("rst_rready",  256'(o_rready),    256'(0));
    chk("rst_done",    256'(o_mem_done),  256'(0));
    chk("rst_buserr",  256'(o_bus_err),   256'(0));
    chk("rst_araddr",  256'(o_araddr),    256'(0));
    chk("rst_line",    o_line_data,       256'(0));
    chk("rst_state",   256'(o_dbg_state), 256'(0));
    i_rst_n = 1'b1;
    tick();
    chk("idle_arvalid", 256'(o_arvalid), 256'(0));

    // 1: zero-wait slave, done lands in the cycle right after the 4th beat.
    start_req(64'h0000_0000_1000_0040, 64'h0000_0000_1000_0040, 0);
    beat(64'h1111_0000_0000_0000, 2'b00, 1'b0, 0);
    beat(64'h1111_0000_0000_0001, 2'b00, 1'b0, 0);
    beat(64'h1111_0000_0000_0002, 2'b00, 1'b0, 0);
    beat(64'h1111_0000_0000_0003, 2'b00, 1'b1, 0);
    chk("t1_done",   256'(o_mem_done), 256'(1));
    chk("t1_line",   o_line_data,
        {64'h1111_0000_0000_0003, 64'h1111_0000_0000_0002,
         64'h1111_0000_0000_0001, 64'h1111_0000_0000_0000});
    chk("t1_buserr", 256'(o_bus_err),  256'(0));
    tick();
    chk("t1_done_low", 256'(o_mem_done), 256'(0));
    chk("t1_line_held", o_line_data,
        {64'h1111_0000_0000_0003, 64'h1111_0000_0000_0002,
         64'h1111_0000_0000_0001, 64'h1111_0000_0000_0000});

    // 2: AR stalled 5 cycles, gapped beats, request high through DONE.
    start_req(64'h0000_0000_2000_0080, 64'h0000_0000_2000_0080, 5);
    beat(64'h2222_aaaa_0000_0000, 2'b00, 1'b0, 2);
    beat(64'h2222_aaaa_0000_0001, 2'b00, 1'b0, 1);
    beat(64'h2222_aaaa_0000_0002, 2'b00, 1'b0, 0);
    i_mem_req  = 1'b1;
    i_mem_addr = 64'h0000_0000_2000_0080;
    beat(64'h2222_aaaa_0000_0003, 2'b00, 1'b1, 3);
    chk("t2_done", 256'(o_mem_done), 256'(1));
    chk("t2_line", o_line_data,
        {64'h2222_aaaa_0000_0003, 64'h2222_aaaa_0000_0002,
         64'h2222_aaaa_0000_0001, 64'h2222_aaaa_0000_0000});
    tick();
    chk("t2_after_done",    256'(o_mem_done),  256'(0));
    chk("t2_no_req_in_done", 256'(o_arvalid),  256'(0));
    chk("t2_idle_state",    256'(o_dbg_state), 256'(0));
    i_mem_req = 1'b0;
    tick();
    chk("t2_single_pulse", 256'(o_mem_done), 256'(0));
    chk("t2_still_idle",   256'(o_arvalid),  256'(0));

    // 3: SLVERR on beat 1 sets the sticky error; line still completes.
    start_req(64'h0000_0000_3000_0000, 64'h0000_0000_3000_0000, 0);
    beat(64'h3333_0000_0000_0000, 2'b00, 1'b0, 0);
    beat(64'h3333_0000_0000_0001, 2'b10, 1'b0, 0);
    chk("t3_err_set", 256'(o_bus_err), 256'(1));
    beat(64'h3333_0000_0000_0002, 2'b00, 1'b0, 0);
    beat(64'h3333_0000_0000_0003, 2'b00, 1'b1, 0);
    chk("t3_done", 256'(o_mem_done), 256'(1));
    chk("t3_line", o_line_data,
        {64'h3333_0000_0000_0003, 64'h3333_0000_0000_0002,
         64'h3333_0000_0000_0001, 64'h3333_0000_0000_0000});
    tick();
    tick();
    chk("t3_err_sticky", 256'(o_bus_err), 256'(1));

    // 4: early rlast on beat 1 ends the burst and flags an error.
    do_reset();
    chk("t4_err_cleared", 256'(o_bus_err), 256'(0));
    start_req(64'h0000_0000_4000_0020, 64'h0000_0000_4000_0020, 0);
    beat(64'h4444_0000_0000_0000, 2'b00, 1'b0, 0);
    beat(64'h4444_0000_0000_0001, 2'b00, 1'b1, 0);
    chk("t4_early_done", 256'(o_mem_done), 256'(1));
    chk("t4_early_err",  256'(o_bus_err),  256'(1));
    chk("t4_early_line", o_line_data,
        {128'h0, 64'h4444_0000_0000_0001, 64'h4444_0000_0000_0000});
    tick();
    chk("t4_done_low", 256'(o_mem_done), 256'(0));
    start_req(64'h0000_0000_4000_0100, 64'h0000_0000_4000_0100, 0);
    beat(64'h4444_1111_0000_0000, 2'b00, 1'b0, 0);
    beat(64'h4444_1111_0000_0001, 2'b00, 1'b0, 0);
    beat(64'h4444_1111_0000_0002, 2'b00, 1'b0, 0);
    beat(64'h4444_1111_0000_0003, 2'b00, 1'b1, 0);
    chk("t4_next_done", 256'(o_mem_done), 256'(1));
    chk("t4_next_line", o_line_data,
        {64'h4444_1111_0000_0003, 64'h4444_1111_0000_0002,
         64'h4444_1111_0000_0001, 64'h4444_1111_0000_0000});
    chk("t4_err_sticky", 256'(o_bus_err), 256'(1));
    tick();

    // 4b: fourth beat without rlast still ends the burst, with an error.
    do_reset();
    start_req(64'h0000_0000_4800_0000, 64'h0000_0000_4800_0000, 0);
    beat(64'h4848_0000_0000_0000, 2'b00, 1'b0, 0);
    beat(64'h4848_0000_0000_0001, 2'b00, 1'b0, 0);
    beat(64'h4848_0000_0000_0002, 2'b00, 1'b0, 0);
    chk("t4b_no_err_yet", 256'(o_bus_err), 256'(0));
    beat(64'h4848_0000_0000_0003, 2'b00, 1'b0, 0);
    chk("t4b_done", 256'(o_mem_done), 256'(1));
    chk("t4b_err",  256'(o_bus_err),  256'(1));
    chk("t4b_line", o_line_data,
        {64'h4848_0000_0000_0003, 64'h4848_0000_0000_0002,
         64'h4848_0000_0000_0001, 64'h4848_0000_0000_0000});
    tick();

    // 5: reset asserted mid-cycle while beat 2 is on the bus.
    do_reset();
    start_req(64'h0000_0000_5000_0000, 64'h0000_0000_5000_0000, 0);
    beat(64'h5555_0000_0000_0000, 2'b00, 1'b0, 0);
    beat(64'h5555_0000_0000_0001, 2'b00, 1'b0, 0);
    i_rvalid = 1'b1;
    i_rdata  = 64'h5555_0000_0000_0002;
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("t5_rst_rready",  256'(o_rready),    256'(0));
    chk("t5_rst_arvalid", 256'(o_arvalid),   256'(0));
    chk("t5_rst_done",    256'(o_mem_done),  256'(0));
    chk("t5_rst_araddr",  256'(o_araddr),    256'(0));
    chk("t5_rst_line",    o_line_data,       256'(0));
    chk("t5_rst_state",   256'(o_dbg_state), 256'(0));
    i_rvalid = 1'b0;
    i_rdata  = '0;
    tick();
    i_rst_n = 1'b1;
    tick();
    start_req(64'h0000_0000_5000_0040, 64'h0000_0000_5000_0040, 0);
    beat(64'h5555_1111_0000_0000, 2'b00, 1'b0, 0);
    beat(64'h5555_1111_0000_0001, 2'b00, 1'b0, 0);
    beat(64'h5555_1111_0000_0002, 2'b00, 1'b0, 0);
    beat(64'h5555_1111_0000_0003, 2'b00, 1'b1, 0);
    chk("t5_done",   256'(o_mem_done), 256'(1));
    chk("t5_line",   o_line_data,
        {64'h5555_1111_0000_0003, 64'h5555_1111_0000_0002,
         64'h5555_1111_0000_0001, 64'h5555_1111_0000_0000});
    chk("t5_buserr", 256'(o_bus_err), 256'(0));
    tick();

    // 6: unaligned request; wrap mode starts at word 2, incr mode at the base.
    start_req(64'h0000_0000_6000_0050, EXP6_ADDR, 0);
    beat(64'h6666_0000_0000_00b0, 2'b00, 1'b0, 0);
    beat(64'h6666_0000_0000_00b1, 2'b00, 1'b0, 0);
    beat(64'h6666_0000_0000_00b2, 2'b00, 1'b0, 0);
    beat(64'h6666_0000_0000_00b3, 2'b00, 1'b1, 0);
    chk("t6_done", 256'(o_mem_done), 256'(1));
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    chk("t6_line", o_line_data,
        {64'h6666_0000_0000_00b1, 64'h6666_0000_0000_00b0,
         64'h6666_0000_0000_00b3, 64'h6666_0000_0000_00b2});
`else
    chk("t6_line", o_line_data,
        {64'h6666_0000_0000_00b3, 64'h6666_0000_0000_00b2,
         64'h6666_0000_0000_00b1, 64'h6666_0000_0000_00b0});
`endif
    chk("t6_buserr", 256'(o_bus_err), 256'(0));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
